// File: rtl/dino_pkg.sv
// Shared types for the dino player controller.
// State encoding and obstacle line width.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    AIRBORNE = 2'd2,
    OVER     = 2'd3
  } state_t;

  localparam int LINE_W = 8;

endpackage

// File: rtl/dino_btn_sync.sv
// Jump button synchroniser with registered rising-edge pulse.
// A held button yields exactly one pulse.
module dino_btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse_out
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync      <= '0;
      prev      <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], btn_in};
      prev      <= sync[SYNC_STAGES-1];
      pulse_out <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/dino_player_ctrl.sv
// Dino player FSM: jump, collision, score, game over.
// Optional high score register when DINO_HISCORE_EN is defined.
module dino_player_ctrl
  import dino_pkg::*;
#(
  parameter int PLAYER_POS  = 0,
  parameter int JUMP_STEPS  = 2,
  parameter int SCORE_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LINE_W-1:0]  ledLine,
  input  logic               line_step,
  input  logic               jump_btn,
  output logic               player_led,
  output logic               jumping,
  output logic               collision,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
`ifdef DINO_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore
`endif
);

  localparam int CW = $clog2(JUMP_STEPS + 1);
  localparam logic [CW-1:0] JMAX = CW'(JUMP_STEPS);
  localparam logic [CW-1:0] JONE = CW'(1);
  localparam logic [SCORE_W-1:0] SMAX = '1;

  state_t             state;
  state_t             state_n;
  logic [CW-1:0]      jcnt;
  logic [CW-1:0]      jcnt_n;
  logic [SCORE_W-1:0] score_n;
  logic [SCORE_W-1:0] score_inc;
  logic               coll_n;
  logic               hit;
  logic               jump_pulse;

  dino_btn_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (jump_btn),
    .pulse_out(jump_pulse)
  );

  assign hit       = ledLine[PLAYER_POS];
  assign score_inc = (score == SMAX) ? score : score + 1'b1;

  // Hit outranks both the jump and the score step in RUN.
  always_comb begin
    state_n = state;
    jcnt_n  = jcnt;
    score_n = score;
    coll_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (jump_pulse) begin
          state_n = RUN;
          score_n = '0;
        end
      end
      RUN: begin
        if (hit) begin
          state_n = OVER;
          coll_n  = 1'b1;
        end else begin
          if (line_step)
            score_n = score_inc;
          if (jump_pulse) begin
            state_n = AIRBORNE;
            jcnt_n  = JMAX;
          end
        end
      end
      AIRBORNE: begin
        if (line_step) begin
          score_n = score_inc;
          jcnt_n  = jcnt - 1'b1;
          if (jcnt == JONE)
            state_n = RUN;
        end
      end
      OVER: begin
        if (jump_pulse) begin
          state_n = IDLE;
          score_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      jcnt       <= '0;
      score      <= '0;
      collision  <= 1'b0;
      player_led <= 1'b0;
      jumping    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      jcnt       <= jcnt_n;
      score      <= score_n;
      collision  <= coll_n;
      player_led <= (state_n == RUN);
      jumping    <= (state_n == AIRBORNE);
      game_over  <= (state_n == OVER);
    end
  end

`ifdef DINO_HISCORE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      hiscore <= '0;
    else if (coll_n && (score > hiscore))
      hiscore <= score;
  end
`endif

endmodule
